// File: rtl/clk_enable_gen_pkg.sv
// Shared types, defaults and helpers for the fractional clock-enable generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_enable_gen_pkg;

    localparam int DEF_ACC_W       = 32;
    localparam int DEF_LOCK_CYCLES = 16;

    // Widest channel index (16 channels) and widest increment the pending slot can hold.
    localparam int MAX_CHAN_W = 4;
    localparam int MAX_INC_W  = 64;

    typedef enum logic {
        SETTLING = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // One pending increment write. Fields are sized for the largest build
    // and zero-extended from the actual CHAN_W/ACC_W of an instance.
    typedef struct packed {
        logic [MAX_CHAN_W-1:0] chan;
        logic [MAX_INC_W-1:0]  inc;
    } cfg_req_t;

    // Channel select width, never narrower than one bit.
    function automatic int chan_w(input int num_clocks);
        return (num_clocks > 1) ? $clog2(num_clocks) : 1;
    endfunction

    // Increment giving f_out from f_ref with a width-bit accumulator, rounded to nearest.
    function automatic logic [MAX_INC_W-1:0] calc_inc(input longint unsigned f_out_hz,
                                                      input longint unsigned f_ref_hz,
                                                      input int              width);
        logic [127:0] num;
        num = (128'(f_out_hz) << width) + 128'(f_ref_hz / 2);
        return MAX_INC_W'(num / 128'(f_ref_hz));
    endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Increment-write port of clk_enable_gen: valid/ready with channel + increment payload.
// Latency: n/a (wires only).
// Backpressure: cfg_ready low while a write is pending; requester holds data until accepted.
interface clk_enable_gen_if
    import clk_enable_gen_pkg::*;
#(
    parameter int CHAN_W = 1,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [ACC_W-1:0]  cfg_inc;

    modport master (output cfg_valid, output cfg_chan, output cfg_inc, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_chan, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/cegen_nco_chan.sv
// One NCO channel: phase accumulator, increment register reloaded on carry, pulse output.
// Latency: clk_en is the registered carry, rising on the edge the accumulator wraps.
// Backpressure: load_done marks the edge a requested increment is taken (carry or idle inc).
// Ports: refclk/rst (sync, active high); load_req/load_inc from the pending slot;
//        load_done back to it; clk_en pulse and outclk (accumulator MSB).
module cegen_nco_chan #(
    parameter int               ACC_W     = 32,
    parameter logic [ACC_W-1:0] RESET_INC = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load_req,
    input  logic [ACC_W-1:0] load_inc,
    output logic             load_done,
    output logic             clk_en,
    output logic             outclk
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             clk_en_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Swapping the increment only at a wrap keeps the phase continuous, so no
    // runt period appears. A stopped channel never wraps, so it swaps at once.
    assign load_done = load_req && (sum[ACC_W] || (inc_q == '0));

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q    <= '0;
            inc_q    <= RESET_INC;
            clk_en_q <= 1'b0;
        end else begin
            acc_q    <= sum[ACC_W-1:0];
            clk_en_q <= sum[ACC_W];
            if (load_done) begin
                inc_q <= load_inc;
            end
        end
    end

    assign clk_en = clk_en_q;
    assign outclk = acc_q[ACC_W-1];

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator (NCO per channel) with run-time increment writes.
// Latency: clk_en/outclk registered; a write takes effect at the target channel's next wrap.
// Backpressure: single pending slot; cfg_ready low from acceptance until the cycle after apply.
// Ports: refclk, rst (sync, active high); cfg (clk_enable_gen_if.slave);
//        clk_en[NUM_CLOCKS], outclk[NUM_CLOCKS], locked.
// Build option: CEGEN_GATE_UNLOCKED_EN forces clk_en/outclk low while locked is low.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 2,
    parameter int                          ACC_W       = DEF_ACC_W,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] RESET_INC   = {32'h451EB852, 32'h6E978D50},
    parameter int                          LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                  refclk,
    input  logic                  rst,
    clk_enable_gen_if.slave       cfg,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    cfg_req_t              pend_q;
    cfg_req_t              req_in;
    logic                  pend_vld_q;
    logic                  xfer;
    logic                  chan_ok;
    logic                  applied;
    logic                  pend_done;
    logic [NUM_CLOCKS-1:0] load_req;
    logic [NUM_CLOCKS-1:0] load_done;
    logic [NUM_CLOCKS-1:0] raw_en;
    logic [NUM_CLOCKS-1:0] raw_oc;

    lock_state_t           state_q;
    lock_state_t           state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  locked_raw;

    // ---------------- pending slot and handshake ----------------
    assign cfg.cfg_ready = ~pend_vld_q;
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        req_in      = '0;
        req_in.chan = MAX_CHAN_W'(cfg.cfg_chan);
        req_in.inc  = MAX_INC_W'(cfg.cfg_inc);
    end

    assign chan_ok = (32'(pend_q.chan) < NUM_CLOCKS);
    assign applied = |load_done;
    // Writes to a non-existent channel sit in the slot for one cycle, then vanish.
    assign pend_done = pend_vld_q && (applied || !chan_ok);

    always_ff @(posedge refclk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else if (xfer) begin
            pend_vld_q <= 1'b1;
            pend_q     <= req_in;
        end else if (pend_done) begin
            pend_vld_q <= 1'b0;
        end
    end

    if (ACC_W < MAX_INC_W) begin : g_inc_hi
        logic unused_inc_hi;
        assign unused_inc_hi = |pend_q.inc[MAX_INC_W-1:ACC_W];
    end

    // ---------------- channels ----------------
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        assign load_req[i] = pend_vld_q && (pend_q.chan == MAX_CHAN_W'(i));

        cegen_nco_chan #(
            .ACC_W     (ACC_W),
            .RESET_INC (RESET_INC[i*ACC_W +: ACC_W])
        ) u_nco (
            .refclk    (refclk),
            .rst       (rst),
            .load_req  (load_req[i]),
            .load_inc  (pend_q.inc[ACC_W-1:0]),
            .load_done (load_done[i]),
            .clk_en    (raw_en[i]),
            .outclk    (raw_oc[i])
        );
    end

    // ---------------- lock sequencing ----------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= SETTLING;
            cnt_q   <= CNT_W'(LOCK_CYCLES);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (applied) begin
            // Any increment change restarts the settle window, locked or not.
            state_d = SETTLING;
            cnt_d   = CNT_W'(LOCK_CYCLES);
        end else if (state_q == SETTLING) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = LOCKED;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign locked_raw = (state_q == LOCKED);
    assign locked     = locked_raw;

`ifdef CEGEN_GATE_UNLOCKED_EN
    // Accumulators keep running underneath, so phase is intact when the gate opens.
    assign clk_en = raw_en & {NUM_CLOCKS{locked_raw}};
    assign outclk = raw_oc & {NUM_CLOCKS{locked_raw}};
`else
    assign clk_en = raw_en;
    assign outclk = raw_oc;
`endif

endmodule
